// File: rtl/result_display.sv
// result_display: double-dabble BCD conversion of a 16-bit result driving a 4-digit multiplexed 7-segment display
// Ports: clk, rst (sync, active high); result_in/load capture a value; busy/ready/bcd_out/overflow report the
// conversion; seg {g,f,e,d,c,b,a}, dp, an (an[0] rightmost) drive the display, all active low.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1 when not in overflow.
module result_display #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] result_in,
  input  logic        load,
  output logic        busy,
  output logic        ready,
  output logic [19:0] bcd_out,
  output logic        overflow,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [15:0] bin;
  logic [19:0] scratch, adj;
  logic [3:0] cnt;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0] sel;
  logic [3:0] digit, lz;
  logic blank;
  for (genvar i = 0; i < 5; i++) begin : g_adj
    assign adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      ready <= 1'b0;
      bcd_out <= '0;
      overflow <= 1'b0;
      bin <= '0;
      scratch <= '0;
      cnt <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (load) begin
          bin <= result_in;
          scratch <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {scratch, bin} <= {adj, bin} << 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            busy <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bcd_out <= scratch;
          overflow <= scratch[19:16] != 4'd0;
          ready <= 1'b1;
          if (load) begin
            bin <= result_in;
            scratch <= '0;
            cnt <= '0;
            busy <= 1'b1;
            state <= SHIFT;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: pat = 7'b1000000;
      4'd1: pat = 7'b1111001;
      4'd2: pat = 7'b0100100;
      4'd3: pat = 7'b0110000;
      4'd4: pat = 7'b0011001;
      4'd5: pat = 7'b0010010;
      4'd6: pat = 7'b0000010;
      4'd7: pat = 7'b1111000;
      4'd8: pat = 7'b0000000;
      4'd9: pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
  endfunction
  assign sel = refresh[REFRESH_BITS-1 -: 2];
  assign digit = bcd_out[{sel, 2'b00} +: 4];
  // lz[k]: digit k and every displayed digit above it are zero
  assign lz[3] = bcd_out[15:12] == 4'd0;
  assign lz[2] = lz[3] && bcd_out[11:8] == 4'd0;
  assign lz[1] = lz[2] && bcd_out[7:4] == 4'd0;
  assign lz[0] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = !overflow && lz[sel];
`else
  assign blank = 1'b0 & lz[sel];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh <= '0;
      an <= 4'b1110;
      seg <= 7'b1000000;
      dp <= 1'b1;
    end else begin
      refresh <= refresh + 1'b1;
      an <= ~(4'b0001 << sel);
      seg <= blank ? 7'b1111111 : pat(digit);
      dp <= ~overflow;
    end
  end
endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Sequential reader of the 16-bit calculator result that the arithmetic unit writes.
- Converts an unsigned binary result to 5-digit BCD with an iterative double-dabble state machine.
- Drives the board's 4-digit multiplexed seven-segment display from the latched BCD value.
- Sits between result storage (the 16-bit result bus plus a load strobe) and the FPGA display pins.

Parameters:
- REFRESH_BITS, 18: width of the free-running refresh counter. Digit select is counter[REFRESH_BITS-1:REFRESH_BITS-2]; each digit is lit for 2^(REFRESH_BITS-2) clocks.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- result_in  input  16  unsigned binary value to display.
- load  input  1  1-cycle strobe; samples result_in when accepted.
- busy  output  1  high while conversion is in progress.
- ready  output  1  1-cycle pulse when bcd_out is updated.
- bcd_out  output  20  latched BCD, digit4..digit0, 4 bits per digit.
- overflow  output  1  high when latched value > 9999.
- seg  output  7  {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.
- an  output  4  digit enables, active low; an[0] is the rightmost digit.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values:
  - FSM in IDLE; busy=0, ready=0, bcd_out=0, overflow=0.
  - Refresh counter=0, an=4'b1110, seg=7'b1000000 ('0'), dp=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 captures result_in into the binary shift register.
  - Clears the 20-bit scratch register and the 4-bit shift count.
  - Moves to SHIFT; busy=1 from the next cycle.
- SHIFT, one iteration per clock:
  - Every scratch nibble >=5 gets +3.
  - Then {scratch, bin} shifts left by 1.
  - Count increments; after the 16th iteration the FSM moves to DONE.
- DONE, one cycle:
  - Scratch is copied to bcd_out; overflow=(scratch[19:16]!=0).
  - ready=1 for this cycle only; busy=0.
  - Next state is IDLE, or SHIFT if load=1 in this cycle (load accepted and a new capture made).
- Latency: for load sampled at edge N, bcd_out is updated and ready is high in the cycle after edge N+17.
- load while in SHIFT is ignored; the in-flight conversion completes unchanged.
- bcd_out and the display hold the previous value for the whole conversion; there is no flicker or partial value.
- rst mid-conversion:
  - Conversion is abandoned, state returns to IDLE, bcd_out=0, no ready pulse.
- Display:
  - Refresh counter is free-running and wraps modulo 2^REFRESH_BITS.
  - sel = counter's top two bits. sel=0..3 drives an with only bit sel low and seg = pattern of bcd_out digit sel.
  - Patterns, in {g,f,e,d,c,b,a} order:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
    - Any non-BCD nibble = 1111111.
  - Outputs seg/an/dp are registered: one clock after the select change.
- Overflow: digit4 is not displayed. When overflow=1, dp=0 on every digit; otherwise dp=1.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: display digit k (k=3..1) shows seg=7'b1111111 when digit k and all higher displayed digits are 0. Digit 0 is never blanked. No blanking when overflow=1.
- Undefined: all four digits are always shown, including leading zeros.
- bcd_out is identical in both builds.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles.
  - Response: an=1110, seg=1000000, dp=1, bcd_out=0, busy=0, ready=0.
- Basic conversion (REFRESH_BITS=4):
  - Stimulus: load 16'd1234.
  - Response: busy high for 16 cycles; ready pulses once 17 clocks after load; bcd_out=20'h01234, overflow=0.
  - Display: an steps 1110/1101/1011/0111 with seg 0011001/0110000/0100100/1111001.
- Overflow:
  - Stimulus: load 16'd65025.
  - Response: bcd_out=20'h65025, overflow=1, dp=0 on all digits; displayed digits read 5,0,2,5 (digit 3 = 5).
- Load while busy:
  - Stimulus: load 16'd42, then load 16'd999 four cycles later.
  - Response: exactly one ready pulse; bcd_out=20'h00042.
- Reset mid-conversion:
  - Stimulus: load 16'd500, then rst at the 8th SHIFT cycle.
  - Response: no ready pulse, bcd_out=0, busy=0; a following load 16'd7 converts normally to 20'h00007.
- Leading-zero blanking:
  - Stimulus: load 16'd7, build with LEADING_ZERO_BLANK_EN.
  - Response: digits 3..1 seg=1111111, digit 0 seg=1111000.
  - Without the macro: digits 3..1 seg=1000000.
